// File: rtl/cmd_encod_arbiter.sv
// rtl/cmd_encod_arbiter.sv - round-robin arbiter sharing the linear rd/wr command encoders among channels
// Captures encoder words into the sequence memory and hands each finished sequence to the PHY sequencer.
module cmd_encod_arbiter #(
    parameter int NUM_CHN        = 4,
    parameter int ADDRESS_NUMBER = 15,
    parameter int COLADDR_NUMBER = 10,
    parameter int SEQ_ADDR_BITS  = 5
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en,
    input  logic [NUM_CHN-1:0]                  chn_want,
    input  logic [NUM_CHN-1:0]                  chn_wr,
    input  logic [3*NUM_CHN-1:0]                chn_bank,
    input  logic [ADDRESS_NUMBER*NUM_CHN-1:0]   chn_row,
    input  logic [COLADDR_NUMBER*NUM_CHN-1:0]   chn_col,
    input  logic [6*NUM_CHN-1:0]                chn_num128,
    output logic [NUM_CHN-1:0]                  grant,
    output logic [2:0]                          bank_out,
    output logic [ADDRESS_NUMBER-1:0]           row_out,
    output logic [COLADDR_NUMBER-1:0]           col_out,
    output logic [5:0]                          num128_out,
    output logic                                start_rd,
    output logic                                start_wr,
    input  logic [31:0]                         enc_cmd,
    input  logic                                enc_wr,
    input  logic                                enc_done,
    output logic [SEQ_ADDR_BITS-1:0]            seq_waddr,
    output logic [31:0]                         seq_wdata,
    output logic                                seq_we,
    output logic                                seq_run,
    input  logic                                seq_done,
    output logic                                busy,
    output logic                                overflow
);

    localparam int CW = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
    localparam logic [SEQ_ADDR_BITS-1:0] LAST_ADDR = {SEQ_ADDR_BITS{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_ENCODE,
        S_RUN
    } state_t;

    state_t                   state;
    logic [CW-1:0]            rr;
    logic [CW-1:0]            sel;
    logic [CW-1:0]            idx;
    logic                     found;
    logic [SEQ_ADDR_BITS-1:0] waddr;
    logic                     full;
    logic                     enc_settled;

    // Search starts just after the last winner so a held request cannot starve others.
    always_comb begin
        sel   = rr;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_CHN; i++) begin
            idx = CW'((int'(rr) + i) % NUM_CHN);
            if (!found && chn_want[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rr          <= CW'(NUM_CHN - 1);
            waddr       <= '0;
            full        <= 1'b0;
            enc_settled <= 1'b0;
            grant       <= '0;
            bank_out    <= '0;
            row_out     <= '0;
            col_out     <= '0;
            num128_out  <= '0;
            start_rd    <= 1'b0;
            start_wr    <= 1'b0;
            seq_waddr   <= '0;
            seq_wdata   <= '0;
            seq_we      <= 1'b0;
            seq_run     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            grant    <= '0;
            start_rd <= 1'b0;
            start_wr <= 1'b0;
            seq_we   <= 1'b0;
            seq_run  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en && found) begin
                        state       <= S_GRANT;
                        grant       <= NUM_CHN'(1) << sel;
                        bank_out    <= chn_bank[3*int'(sel) +: 3];
                        row_out     <= chn_row[ADDRESS_NUMBER*int'(sel) +: ADDRESS_NUMBER];
                        col_out     <= chn_col[COLADDR_NUMBER*int'(sel) +: COLADDR_NUMBER];
                        num128_out  <= chn_num128[6*int'(sel) +: 6];
                        start_wr    <= chn_wr[sel];
                        start_rd    <= !chn_wr[sel];
                        rr          <= sel;
                        waddr       <= '0;
                        full        <= 1'b0;
                        enc_settled <= 1'b0;
                    end
                end
                S_GRANT: begin
                    state <= S_ENCODE;
                end
                S_ENCODE: begin
                    // enc_done may still show the previous idle level in the first ENCODE cycle.
                    enc_settled <= 1'b1;
                    if (enc_wr) begin
                        if (full) begin
                            overflow <= 1'b1;
                        end else begin
                            seq_we    <= 1'b1;
                            seq_wdata <= enc_cmd;
                            seq_waddr <= waddr;
                            if (waddr == LAST_ADDR) begin
                                full <= 1'b1;
                            end else begin
                                waddr <= waddr + 1'b1;
                            end
                        end
                    end else if (enc_done && enc_settled) begin
                        state   <= S_RUN;
                        seq_run <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (seq_done) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
